serial_word_aligner: RTL and testbench



---
 rtl/serial_word_aligner.sv | 226 ++++++++++++++++++++++
 tb/tb_serial_word_aligner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_aligner.sv
// serial_word_aligner: bit-serial deserialiser that hunts for TRAIN_PATTERN by bit-slipping and
// delivers aligned WIDTH-bit words once locked. Optional macro SWA_POLARITY_DETECT_EN adds P/N-swap correction.
module serial_word_aligner #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'h5C),
  parameter int unsigned      LOCK_COUNT    = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SDI,
  input  logic             RESYNC,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  output logic             LOCKED,
  output logic             ALIGN_ERR,
  output logic [3:0]       SLIP_CNT
);

  localparam int unsigned      CNT_W       = $clog2(WIDTH);
  localparam int unsigned      RUN_W       = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
  localparam logic [RUN_W-1:0] RUN_MAX     = RUN_W'(WIDTH);
  localparam logic [RUN_W-1:0] RUN_LAST    = RUN_W'(WIDTH - 1);
  localparam logic [3:0]       LOCK_TARGET = 4'(LOCK_COUNT);

  // A pattern with a repeated rotation would let the hunter lock on the wrong boundary.
  function automatic logic rotations_distinct(input logic [WIDTH-1:0] pat);
    logic [WIDTH-1:0] rot;
    rotations_distinct = 1'b1;
    rot = pat;
    for (int i = 1; i < int'(WIDTH); i++) begin
      rot = {rot[WIDTH-2:0], rot[WIDTH-1]};
      if (rot == pat) rotations_distinct = 1'b0;
    end
  endfunction

  if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
    $error("serial_word_aligner: WIDTH must be 4..16");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
    $error("serial_word_aligner: LOCK_COUNT must be 1..15");
  end
  if (!rotations_distinct(TRAIN_PATTERN)) begin : g_bad_pattern
    $error("serial_word_aligner: TRAIN_PATTERN rotations are not distinct");
  end

  typedef enum logic [1:0] {ST_HUNT, ST_VERIFY, ST_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             hold_q, hold_d;
  logic [3:0]       match_cnt_q, match_cnt_d;
  logic [RUN_W-1:0] slip_run_q, slip_run_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             locked_q, locked_d;
  logic             align_err_q, align_err_d;
  logic [3:0]       slip_cnt_q, slip_cnt_d;

  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] word_corr;
  logic             word_done;
  logic             hunt_true;
  logic             hunt_inv;
  logic             slip;
  logic             match_ev;

  // The word under test already includes the bit being sampled this cycle.
  assign word      = {shift_q[WIDTH-2:0], SDI};
  assign word_done = (bit_cnt_q == LAST_BIT);
  assign hunt_true = (word == TRAIN_PATTERN);

`ifdef SWA_POLARITY_DETECT_EN
  logic inv_q, inv_d;

  assign hunt_inv = (word == ~TRAIN_PATTERN);

  always_comb begin
    inv_d = inv_q;
    if (RESYNC) begin
      inv_d = 1'b0;
    end else if (word_done && state_q == ST_HUNT) begin
      if (hunt_true) begin
        inv_d = 1'b0;
      end else if (hunt_inv) begin
        inv_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end
`else
  logic inv_q;

  assign hunt_inv = 1'b0;
  assign inv_q    = 1'b0;
`endif

  assign word_corr = word ^ {WIDTH{inv_q}};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // A word completing in the same cycle as RESYNC is never evaluated.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    slip        = 1'b0;
    match_ev    = 1'b0;
    if (RESYNC) begin
      state_d     = ST_HUNT;
      match_cnt_d = '0;
    end else if (word_done) begin
      case (state_q)
        ST_HUNT: begin
          if (hunt_true || hunt_inv) begin
            match_ev    = 1'b1;
            match_cnt_d = 4'd1;
            state_d     = (LOCK_TARGET == 4'd1) ? ST_LOCKED : ST_VERIFY;
          end else begin
            slip = 1'b1;
          end
        end
        ST_VERIFY: begin
          if (word_corr == TRAIN_PATTERN) begin
            match_ev    = 1'b1;
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 >= LOCK_TARGET) state_d = ST_LOCKED;
          end else begin
            slip        = 1'b1;
            match_cnt_d = '0;
            state_d     = ST_HUNT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dvalid_d = !RESYNC && word_done && (state_q == ST_LOCKED);
    dout_d   = dvalid_d ? word_corr : dout_q;
    locked_d = (state_d == ST_LOCKED);
  end

  // A slip parks the counter at 0 for one extra cycle, pushing the next boundary one bit later.
  always_comb begin
    bit_cnt_d = bit_cnt_q + CNT_W'(1);
    hold_d    = 1'b0;
    if (RESYNC) begin
      bit_cnt_d = '0;
    end else if (slip) begin
      bit_cnt_d = '0;
      hold_d    = 1'b1;
    end else if (hold_q || word_done) begin
      bit_cnt_d = '0;
    end
  end

  // A VERIFY failure re-enters HUNT, so its slip is the first one counted for the new hunt.
  always_comb begin
    slip_cnt_d  = slip_cnt_q;
    slip_run_d  = slip_run_q;
    align_err_d = align_err_q;
    if (RESYNC) begin
      slip_cnt_d  = '0;
      slip_run_d  = '0;
      align_err_d = 1'b0;
    end else if (slip) begin
      if (state_q == ST_VERIFY) begin
        slip_cnt_d = 4'd1;
      end else if (slip_cnt_q != 4'hF) begin
        slip_cnt_d = slip_cnt_q + 4'd1;
      end
      if (slip_run_q != RUN_MAX) slip_run_d = slip_run_q + RUN_W'(1);
      if (slip_run_q >= RUN_LAST) align_err_d = 1'b1;
    end else if (match_ev) begin
      slip_run_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= 1'b0;
      match_cnt_q <= '0;
      slip_run_q  <= '0;
      slip_cnt_q  <= '0;
      align_err_q <= 1'b0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      shift_q     <= word;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      match_cnt_q <= match_cnt_d;
      slip_run_q  <= slip_run_d;
      slip_cnt_q  <= slip_cnt_d;
      align_err_q <= align_err_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      locked_q    <= locked_d;
    end
  end

  assign DOUT      = dout_q;
  assign DVALID    = dvalid_q;
  assign LOCKED    = locked_q;
  assign ALIGN_ERR = align_err_q;
  assign SLIP_CNT  = slip_cnt_q;

endmodule

// File: tb/tb_serial_word_aligner.sv
// Directed bench for serial_word_aligner: aligned/offset lock, slip saturation, RESYNC, mid-word reset
// and the SWA_POLARITY_DETECT_EN option (checked in whichever build the macro selects).
module tb_serial_word_aligner;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       SDI;
  logic       RESYNC;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       LOCKED;
  logic       ALIGN_ERR;
  logic [3:0] SLIP_CNT;

  int cmpCount = 0;
  int errCount = 0;
  int dvalidCount = 0;

  serial_word_aligner #(
    .WIDTH(8),
    .TRAIN_PATTERN(8'h5C),
    .LOCK_COUNT(4)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .SDI(SDI),
    .RESYNC(RESYNC),
    .DOUT(DOUT),
    .DVALID(DVALID),
    .LOCKED(LOCKED),
    .ALIGN_ERR(ALIGN_ERR),
    .SLIP_CNT(SLIP_CNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (DVALID === 1'b1) dvalidCount = dvalidCount + 1;
  end

  // Inputs change on the falling edge; outputs are read there too, since they are all registered.
  task automatic sendBit(input logic b);
    SDI = b;
    @(negedge CLK);
  endtask

  task automatic sendWord(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) sendBit(w[i]);
  endtask

  task automatic resetDut();
    RST_N  = 1'b0;
    RESYNC = 1'b0;
    SDI    = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N  = 1'b0;
    RESYNC = 1'b0;
    SDI    = 1'b1;
    repeat (2) @(negedge CLK);
    cmpCount++; if (DOUT !== 8'h00) begin errCount++; $display("[TB] FAIL reset_dout: got %h expected %h", DOUT, 8'h00); end
    cmpCount++; if (DVALID !== 1'b0) begin errCount++; $display("[TB] FAIL reset_dvalid: got %b expected %b", DVALID, 1'b0); end
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL reset_locked: got %b expected %b", LOCKED, 1'b0); end
    cmpCount++; if (ALIGN_ERR !== 1'b0) begin errCount++; $display("[TB] FAIL reset_align_err: got %b expected %b", ALIGN_ERR, 1'b0); end
    cmpCount++; if (SLIP_CNT !== 4'd0) begin errCount++; $display("[TB] FAIL reset_slip_cnt: got %0d expected %0d", SLIP_CNT, 0); end
    RST_N = 1'b1;
  endtask

  task automatic test_aligned_lock();
    logic [7:0] pat;
    logic [7:0] w;
    pat = 8'h5C;
    resetDut();
    repeat (3) sendWord(pat);
    for (int i = 7; i >= 1; i--) sendBit(pat[i]);
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL aligned_lock_early: got %b expected %b", LOCKED, 1'b0); end
    sendBit(pat[0]);
    cmpCount++; if (LOCKED !== 1'b1) begin errCount++; $display("[TB] FAIL aligned_lock_cycle32: got %b expected %b", LOCKED, 1'b1); end
    cmpCount++; if (SLIP_CNT !== 4'd0) begin errCount++; $display("[TB] FAIL aligned_slip_cnt: got %0d expected %0d", SLIP_CNT, 0); end
    cmpCount++; if (DVALID !== 1'b0) begin errCount++; $display("[TB] FAIL aligned_train_no_valid: got %b expected %b", DVALID, 1'b0); end
    sendWord(8'h11);
    cmpCount++; if (DVALID !== 1'b1) begin errCount++; $display("[TB] FAIL data11_valid: got %b expected %b", DVALID, 1'b1); end
    cmpCount++; if (DOUT !== 8'h11) begin errCount++; $display("[TB] FAIL data11_dout: got %h expected %h", DOUT, 8'h11); end
    w = 8'h22;
    sendBit(w[7]);
    cmpCount++; if (DVALID !== 1'b0) begin errCount++; $display("[TB] FAIL data11_pulse_width: got %b expected %b", DVALID, 1'b0); end
    cmpCount++; if (DOUT !== 8'h11) begin errCount++; $display("[TB] FAIL data11_dout_hold: got %h expected %h", DOUT, 8'h11); end
    for (int i = 6; i >= 0; i--) sendBit(w[i]);
    cmpCount++; if (DVALID !== 1'b1) begin errCount++; $display("[TB] FAIL data22_valid: got %b expected %b", DVALID, 1'b1); end
    cmpCount++; if (DOUT !== 8'h22) begin errCount++; $display("[TB] FAIL data22_dout: got %h expected %h", DOUT, 8'h22); end
  endtask

  task automatic test_offset_lock();
    resetDut();
    repeat (3) sendBit(1'b0);
    repeat (6) sendWord(8'h5C);
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL offset_lock_early: got %b expected %b", LOCKED, 1'b0); end
    sendWord(8'h5C);
    cmpCount++; if (LOCKED !== 1'b1) begin errCount++; $display("[TB] FAIL offset_locked: got %b expected %b", LOCKED, 1'b1); end
    cmpCount++; if (SLIP_CNT !== 4'd3) begin errCount++; $display("[TB] FAIL offset_slip_cnt: got %0d expected %0d", SLIP_CNT, 3); end
    sendWord(8'hA5);
    cmpCount++; if (DVALID !== 1'b1) begin errCount++; $display("[TB] FAIL offset_data_valid: got %b expected %b", DVALID, 1'b1); end
    cmpCount++; if (DOUT !== 8'hA5) begin errCount++; $display("[TB] FAIL offset_data_dout: got %h expected %h", DOUT, 8'hA5); end
  endtask

  task automatic test_align_err();
    resetDut();
    repeat (70) sendBit(1'b0);
    cmpCount++; if (ALIGN_ERR !== 1'b0) begin errCount++; $display("[TB] FAIL align_err_after_7: got %b expected %b", ALIGN_ERR, 1'b0); end
    cmpCount++; if (SLIP_CNT !== 4'd7) begin errCount++; $display("[TB] FAIL slip_cnt_7: got %0d expected %0d", SLIP_CNT, 7); end
    sendBit(1'b0);
    cmpCount++; if (ALIGN_ERR !== 1'b1) begin errCount++; $display("[TB] FAIL align_err_after_8: got %b expected %b", ALIGN_ERR, 1'b1); end
    cmpCount++; if (SLIP_CNT !== 4'd8) begin errCount++; $display("[TB] FAIL slip_cnt_8: got %0d expected %0d", SLIP_CNT, 8); end
    repeat (100) sendBit(1'b0);
    cmpCount++; if (SLIP_CNT !== 4'd15) begin errCount++; $display("[TB] FAIL slip_cnt_saturate: got %0d expected %0d", SLIP_CNT, 15); end
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL zeros_never_lock: got %b expected %b", LOCKED, 1'b0); end
    cmpCount++; if (ALIGN_ERR !== 1'b1) begin errCount++; $display("[TB] FAIL align_err_sticky: got %b expected %b", ALIGN_ERR, 1'b1); end
    RESYNC = 1'b1;
    sendBit(1'b0);
    RESYNC = 1'b0;
    cmpCount++; if (ALIGN_ERR !== 1'b0) begin errCount++; $display("[TB] FAIL resync_align_err: got %b expected %b", ALIGN_ERR, 1'b0); end
    cmpCount++; if (SLIP_CNT !== 4'd0) begin errCount++; $display("[TB] FAIL resync_slip_cnt: got %0d expected %0d", SLIP_CNT, 0); end
  endtask

  task automatic test_verify_fail();
    logic [7:0] w;
    resetDut();
    repeat (4) sendWord(8'h5C);
    w = 8'h33;
    for (int i = 7; i >= 1; i--) sendBit(w[i]);
    RESYNC = 1'b1;
    sendBit(w[0]);
    RESYNC = 1'b0;
    cmpCount++; if (DVALID !== 1'b0) begin errCount++; $display("[TB] FAIL resync_discard_word: got %b expected %b", DVALID, 1'b0); end
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL resync_drop_lock: got %b expected %b", LOCKED, 1'b0); end
    repeat (2) sendWord(8'h5C);
    sendWord(8'hFF);
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL verify_fail_locked: got %b expected %b", LOCKED, 1'b0); end
    cmpCount++; if (SLIP_CNT !== 4'd1) begin errCount++; $display("[TB] FAIL verify_fail_slip: got %0d expected %0d", SLIP_CNT, 1); end
    sendBit(1'b0);
    repeat (3) sendWord(8'h5C);
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL relock_early: got %b expected %b", LOCKED, 1'b0); end
    sendWord(8'h5C);
    cmpCount++; if (LOCKED !== 1'b1) begin errCount++; $display("[TB] FAIL relock: got %b expected %b", LOCKED, 1'b1); end
    cmpCount++; if (SLIP_CNT !== 4'd1) begin errCount++; $display("[TB] FAIL relock_slip_cnt: got %0d expected %0d", SLIP_CNT, 1); end
  endtask

  task automatic test_reset_midword();
    logic [7:0] w;
    int         snapCount;
    resetDut();
    repeat (4) sendWord(8'h5C);
    sendWord(8'h11);
    cmpCount++; if (DVALID !== 1'b1) begin errCount++; $display("[TB] FAIL midword_pre_valid: got %b expected %b", DVALID, 1'b1); end
    w = 8'h22;
    for (int i = 7; i >= 4; i--) sendBit(w[i]);
    #2 RST_N = 1'b0;
    #1;
    cmpCount++; if (DOUT !== 8'h00) begin errCount++; $display("[TB] FAIL midword_dout: got %h expected %h", DOUT, 8'h00); end
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL midword_locked: got %b expected %b", LOCKED, 1'b0); end
    cmpCount++; if (DVALID !== 1'b0) begin errCount++; $display("[TB] FAIL midword_dvalid: got %b expected %b", DVALID, 1'b0); end
    @(negedge CLK);
    RST_N = 1'b1;
    #1 snapCount = dvalidCount;
    repeat (3) sendWord(8'h5C);
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL midword_relock_early: got %b expected %b", LOCKED, 1'b0); end
    sendWord(8'h5C);
    cmpCount++; if (LOCKED !== 1'b1) begin errCount++; $display("[TB] FAIL midword_relock: got %b expected %b", LOCKED, 1'b1); end
    #1;
    cmpCount++; if (dvalidCount !== snapCount) begin errCount++; $display("[TB] FAIL midword_no_valid: got %0d pulses expected %0d", dvalidCount - snapCount, 0); end
  endtask

  task automatic test_polarity();
    resetDut();
`ifdef SWA_POLARITY_DETECT_EN
    repeat (3) sendWord(8'hA3);
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL pol_lock_early: got %b expected %b", LOCKED, 1'b0); end
    sendWord(8'hA3);
    cmpCount++; if (LOCKED !== 1'b1) begin errCount++; $display("[TB] FAIL pol_locked: got %b expected %b", LOCKED, 1'b1); end
    sendWord(8'hEE);
    cmpCount++; if (DVALID !== 1'b1) begin errCount++; $display("[TB] FAIL pol_valid: got %b expected %b", DVALID, 1'b1); end
    cmpCount++; if (DOUT !== 8'h11) begin errCount++; $display("[TB] FAIL pol_dout: got %h expected %h", DOUT, 8'h11); end
`else
    repeat (8) sendWord(8'hA3);
    cmpCount++; if (ALIGN_ERR !== 1'b0) begin errCount++; $display("[TB] FAIL nopol_align_err_early: got %b expected %b", ALIGN_ERR, 1'b0); end
    sendWord(8'hA3);
    cmpCount++; if (ALIGN_ERR !== 1'b1) begin errCount++; $display("[TB] FAIL nopol_align_err: got %b expected %b", ALIGN_ERR, 1'b1); end
    cmpCount++; if (LOCKED !== 1'b0) begin errCount++; $display("[TB] FAIL nopol_locked: got %b expected %b", LOCKED, 1'b0); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, compared %0d", cmpCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST_N  = 1'b0;
    RESYNC = 1'b0;
    SDI    = 1'b0;
    test_reset();
    test_aligned_lock();
    test_offset_lock();
    test_align_err();
    test_verify_fail();
    test_reset_midword();
    test_polarity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
